// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan code decoder: prefix FSM, typematic filter, press counter and ASCII FIFO.
// Optional macro KBD_SHIFT_EN enables shift tracking and uppercase letters.
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             code_valid,
  input  logic [7:0]       code,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             key_down,
  output logic [7:0]       last_make,
  output logic [CNT_W-1:0] press_count,
  output logic             shift_active,
  output logic             overflow
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_e;

  state_e             state_q, state_d;
  logic [7:0]         held_q, held_d;
  logic [7:0]         last_q, last_d;
  logic               key_down_q, key_down_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      fill_q, fill_d;
  logic               valid_q, valid_d;
  logic [7:0]         head_q, head_d;
  logic               ovf_q, ovf_d;
  logic               shift_q, shift_d;

  logic               make_ev, brk_ev, repeat_ev, new_make;
  logic               is_shift_code, upper;
  logic [8:0]         lut;
  logic [7:0]         push_data;
  logic               push, pop, full, wr_en;

  // Lowercase lookup; bit 8 marks a letter so shift can uppercase it.
  function automatic logic [8:0] ascii_lut(input logic [7:0] c);
    logic [8:0] r;
    r = 9'h000;
    unique case (c)
      8'h1C: r = {1'b1, 8'h61}; 8'h32: r = {1'b1, 8'h62}; 8'h21: r = {1'b1, 8'h63};
      8'h23: r = {1'b1, 8'h64}; 8'h24: r = {1'b1, 8'h65}; 8'h2B: r = {1'b1, 8'h66};
      8'h34: r = {1'b1, 8'h67}; 8'h33: r = {1'b1, 8'h68}; 8'h43: r = {1'b1, 8'h69};
      8'h3B: r = {1'b1, 8'h6A}; 8'h42: r = {1'b1, 8'h6B}; 8'h4B: r = {1'b1, 8'h6C};
      8'h3A: r = {1'b1, 8'h6D}; 8'h31: r = {1'b1, 8'h6E}; 8'h44: r = {1'b1, 8'h6F};
      8'h4D: r = {1'b1, 8'h70}; 8'h15: r = {1'b1, 8'h71}; 8'h2D: r = {1'b1, 8'h72};
      8'h1B: r = {1'b1, 8'h73}; 8'h2C: r = {1'b1, 8'h74}; 8'h3C: r = {1'b1, 8'h75};
      8'h2A: r = {1'b1, 8'h76}; 8'h1D: r = {1'b1, 8'h77}; 8'h22: r = {1'b1, 8'h78};
      8'h35: r = {1'b1, 8'h79}; 8'h1A: r = {1'b1, 8'h7A};
      8'h45: r = {1'b0, 8'h30}; 8'h16: r = {1'b0, 8'h31}; 8'h1E: r = {1'b0, 8'h32};
      8'h26: r = {1'b0, 8'h33}; 8'h25: r = {1'b0, 8'h34}; 8'h2E: r = {1'b0, 8'h35};
      8'h36: r = {1'b0, 8'h36}; 8'h3D: r = {1'b0, 8'h37}; 8'h3E: r = {1'b0, 8'h38};
      8'h46: r = {1'b0, 8'h39};
      8'h29: r = {1'b0, 8'h20}; 8'h5A: r = {1'b0, 8'h0D};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  // Prefix FSM next state
  always_comb begin
    state_d = state_q;
    if (code_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (code == BRK_CODE)      state_d = S_BRK;
          else if (code == EXT_CODE) state_d = S_EXT;
        end
        S_BRK:   state_d = S_IDLE;
        S_EXT:   state_d = (code == BRK_CODE) ? S_EXT_BRK : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign make_ev = code_valid && (state_q == S_IDLE) && (code != BRK_CODE) && (code != EXT_CODE);
  assign brk_ev  = code_valid && (state_q == S_BRK);

  logic [1:0] shift_bits_q, shift_bits_d;
`ifdef KBD_SHIFT_EN
  assign is_shift_code = (code == 8'h12) || (code == 8'h59);
  assign upper         = |shift_bits_q;

  always_comb begin
    shift_bits_d = shift_bits_q;
    if (make_ev && code == 8'h12) shift_bits_d[0] = 1'b1;
    if (make_ev && code == 8'h59) shift_bits_d[1] = 1'b1;
    if (brk_ev && code == 8'h12)  shift_bits_d[0] = 1'b0;
    if (brk_ev && code == 8'h59)  shift_bits_d[1] = 1'b0;
  end
`else
  assign is_shift_code = 1'b0;
  assign upper         = 1'b0;
  assign shift_bits_d  = 2'b00;
`endif
  assign shift_d = |shift_bits_d;

  // Held key tracking and press counting
  always_comb begin
    repeat_ev  = make_ev && key_down_q && (code == held_q);
    new_make   = make_ev && !is_shift_code && !repeat_ev;
    held_d     = held_q;
    last_d     = last_q;
    key_down_d = key_down_q;
    cnt_d      = cnt_q;
    if (new_make) begin
      held_d     = code;
      last_d     = code;
      key_down_d = 1'b1;
      cnt_d      = cnt_q + CNT_W'(1);
    end else if (brk_ev && code == held_q) begin
      key_down_d = 1'b0;
    end
  end

  assign lut       = ascii_lut(code);
  assign push_data = (lut[8] && upper) ? (lut[7:0] - 8'h20) : lut[7:0];
  assign push      = new_make && (push_data != 8'h00);

  // FIFO next state; a pop frees the slot a same-cycle push needs
  always_comb begin
    pop    = valid_q && out_ready;
    full   = (fill_q == CW'(FIFO_DEPTH));
    wr_en  = push && (!full || pop);
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    fill_d = fill_q;
    ovf_d  = ovf_q || (push && full && !pop);
    if (wr_en) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    unique case ({wr_en, pop})
      2'b10:   fill_d = fill_q + CW'(1);
      2'b01:   fill_d = fill_q - CW'(1);
      default: fill_d = fill_q;
    endcase
    valid_d = (fill_d != CW'(0));
    head_d  = mem_d[rd_d];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      held_q       <= 8'h00;
      last_q       <= 8'h00;
      key_down_q   <= 1'b0;
      cnt_q        <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      fill_q       <= '0;
      valid_q      <= 1'b0;
      head_q       <= 8'h00;
      ovf_q        <= 1'b0;
      shift_q      <= 1'b0;
      shift_bits_q <= 2'b00;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 8'h00;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      last_q       <= last_d;
      key_down_q   <= key_down_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      fill_q       <= fill_d;
      valid_q      <= valid_d;
      head_q       <= head_d;
      ovf_q        <= ovf_d;
      shift_q      <= shift_d;
      shift_bits_q <= shift_bits_d;
      mem_q        <= mem_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_data     = head_q;
  assign key_down     = key_down_q;
  assign last_make    = last_q;
  assign press_count  = cnt_q;
  assign shift_active = shift_q;
  assign overflow     = ovf_q;

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the byte stream produced by the PS/2 frame receiver (one strobe per validated 8-bit Set-2 scan code) and turns it into key events. Tracks the break prefix (F0) and the extended prefix (E0), suppresses typematic repeats, and maintains a press counter and shift state. Pushes printable key presses as ASCII into a small first-word-fall-through FIFO read by the display/console stage through a valid/ready handshake.

## Interface
- FIFO_DEPTH, 4, ASCII FIFO entries; power of two, at least 2
- CNT_W, 8, press counter width
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- code_valid  in  1  one-cycle strobe; code is valid this cycle
- code  in  8  scan code byte from the receiver
- out_valid  out  1  FIFO non-empty
- out_data  out  8  ASCII at the FIFO head
- out_ready  in  1  consumer accepts the head when out_valid is high
- key_down  out  1  a non-modifier key is currently held
- last_make  out  8  scan code of the most recent new make (non-extended)
- press_count  out  CNT_W  count of new, non-extended make events
- shift_active  out  1  left or right shift is held
- overflow  out  1  sticky; a push was dropped because the FIFO was full

## Operation
- Prefix FSM states: IDLE, BRK, EXT, EXT_BRK. The FSM advances only on code_valid.
  - IDLE: F0 goes to BRK. E0 goes to EXT. Any other code is a make event and stays in IDLE.
  - BRK: any code is a break event and returns to IDLE.
  - EXT: F0 goes to EXT_BRK. Any other code is an extended make and returns to IDLE.
  - EXT_BRK: any code is an extended break and returns to IDLE.
  - Extended events are ignored: no count, no push, no change to held or shift state.
- Make event with code 12 or 59: sets the shift bit for that key. No count, no push.
- Make event with code equal to held_code while key_down=1: typematic repeat. It is ignored.
- Any other make event is a new make:
  - held_code, last_make <= code; key_down <= 1.
  - press_count increments, wrapping from 2^CNT_W-1 to 0.
  - If the ASCII lookup is non-zero, the result is pushed to the FIFO.
- Break event:
  - Code 12 or 59 clears that shift bit.
  - A code equal to held_code clears key_down.
  - Other break codes are ignored.
- ASCII lookup, lowercase:
  - 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m
  - 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z
  - 45..46 digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'
  - 29 gives 0x20. 5A gives 0x0D. Every other code gives 0x00 (not pushed).
  - Letters use uppercase (subtract 0x20) when shift_active=1. Digits are unaffected by shift.
- FIFO:
  - Push is decided from code plus current state, written at the same edge as the FSM update.
  - Pop occurs when out_valid and out_ready are both high.
  - Push while full without a pop: the data is dropped and overflow is set. overflow clears only on reset.
  - Push and pop in the same cycle while full: both succeed and overflow stays 0.
  - Pop while empty is ignored.

## Timing
- Reset values: out_valid 0, out_data 0x00, key_down 0, last_make 0x00, press_count 0, shift_active 0, overflow 0. The FSM resets to IDLE and the FIFO to empty.
- Reset asserted mid-sequence (for example after F0) discards the prefix state and all FIFO contents.
- Latency: code_valid at cycle N into an empty FIFO gives out_valid=1 and out_data valid in cycle N+1. key_down, last_make, press_count and shift_active update in cycle N+1.
- out_data is the registered head entry. It is stable while out_valid=1 and out_ready=0.
- Back-to-back code_valid strobes, one per cycle, are supported.

## Configuration
- KBD_SHIFT_EN defined:
  - Shift tracking and uppercase letters are implemented as described above.
- KBD_SHIFT_EN undefined:
  - No shift logic is built and shift_active is tied to 0.
  - 12 and 59 are treated as ordinary non-printing keys: a new make counts and updates the held state, but nothing is pushed.
  - Letters are always lowercase.

## Test plan
- Press and release: 1C, F0 1C with out_ready=1 gives one pop of 0x61, press_count=1 and last_make=1C, with key_down high then low.
- Typematic: 23 23 23, F0 23 gives a single 0x64 push and press_count=1.
- Shift (KBD_SHIFT_EN): 12, 1C, F0 1C, F0 12, 1C gives 0x41 then 0x61. Shift itself does not count.
- Extended: E0 75, E0 F0 75 gives no push, press_count=0 and the FSM back in IDLE. A following 29 gives 0x20.
- Overflow (FIFO_DEPTH=4, out_ready=0): presses 16 1E 26 25 2E give a FIFO holding 31 32 33 34 and overflow=1. Draining returns exactly those four bytes.
- Reset after F0, then 1C, gives a make event: push 0x61, press_count=1.
